// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: IP/PC1 load, 16-round key schedule and L/R update, FP on completion.
// The round function itself is external (f_r/f_key out, f_out in). Optional macro: DES_KEY_ZEROIZE_EN.
module des_round_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    output logic [31:0] f_r,
    output logic [47:0] f_key,
    input  logic [31:0] f_out,
    output logic        busy,
    output logic        done,
    output logic [63:0] data_out
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Tables use FIPS numbering: table entry n selects vector bit [width-n].
    function automatic logic [63:0] ip_f(input logic [63:0] x);
        ip_f = '0;
        for (int unsigned i = 0; i < 64; i++) ip_f[63-i] = x[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        fp_f = '0;
        for (int unsigned i = 0; i < 64; i++) fp_f[63-i] = x[64-FP_T[i]];
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        pc1_f = '0;
        for (int unsigned i = 0; i < 56; i++) pc1_f[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        pc2_f = '0;
        for (int unsigned i = 0; i < 48; i++) pc2_f[47-i] = x[56-PC2_T[i]];
    endfunction

    state_t      state, state_nxt;
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic [3:0]  round;
    logic        dec_q;
    logic        enc_single, dec_single;
    logic [27:0] c_enc, d_enc, c_nxt, d_nxt;
    logic [55:0] key_src;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ROUND;
            ROUND:   if (round == 4'd15) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Encrypt rotates left before use; decrypt uses current C/D then rotates right for the next round.
    always_comb begin
        enc_single = (round == 4'd0) || (round == 4'd1) || (round == 4'd8) || (round == 4'd15);
        dec_single = (round == 4'd0) || (round == 4'd7) || (round == 4'd14);
        c_enc      = enc_single ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
        d_enc      = enc_single ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
        if (dec_q) begin
            key_src = {c, d};
            if (round == 4'd15) begin
                c_nxt = c;
                d_nxt = d;
            end else if (dec_single) begin
                c_nxt = {c[0], c[27:1]};
                d_nxt = {d[0], d[27:1]};
            end else begin
                c_nxt = {c[1:0], c[27:2]};
                d_nxt = {d[1:0], d[27:2]};
            end
        end else begin
            key_src = {c_enc, d_enc};
            c_nxt   = c_enc;
            d_nxt   = d_enc;
        end
    end

    always_comb begin
        busy  = (state != IDLE);
        f_r   = r;
        f_key = (state == ROUND) ? pc2_f(key_src) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l        <= '0;
            r        <= '0;
            c        <= '0;
            d        <= '0;
            round    <= '0;
            dec_q    <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        {l, r} <= ip_f(data_in);
                        {c, d} <= pc1_f(key_in);
                        dec_q  <= decrypt;
                        round  <= '0;
                    end
                end
                ROUND: begin
                    l     <= r;
                    r     <= l ^ f_out;
                    c     <= c_nxt;
                    d     <= d_nxt;
                    round <= (round == 4'd15) ? round : round + 4'd1;
                end
                FINAL: begin
                    data_out <= fp_f({r, l});
                    done     <= 1'b1;
`ifdef DES_KEY_ZEROIZE_EN
                    l <= '0;
                    r <= '0;
                    c <= '0;
                    d <= '0;
`else
                    l <= l;
                    r <= r;
                    c <= c;
                    d <= d;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: supplies a DES round function (E, S-boxes, P)
// and checks known-answer vectors, handshake timing, ignored starts and reset abort.
module tb_des_round_ctrl;

    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    function automatic logic [31:0] des_f(input logic [31:0] rv, input logic [47:0] kv);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  b;
        int unsigned idx;
        e = '0;
        s = '0;
        for (int unsigned i = 0; i < 48; i++) e[47-i] = rv[32-E_T[i]];
        e = e ^ kv;
        for (int unsigned j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            idx = j * 64 + 32'(b[5]) * 32 + 32'(b[0]) * 16 + 32'(b[4:1]);
            s[31-4*j -: 4] = 4'(SBOX[idx]);
        end
        des_f = '0;
        for (int unsigned i = 0; i < 32; i++) des_f[31-i] = s[32-P_T[i]];
    endfunction

    typedef struct {
        string       name;
        logic        dec;
        logic [63:0] key;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, decrypt;
    logic [63:0] data_in, key_in, data_out;
    logic [31:0] f_r, f_out;
    logic [47:0] f_key;
    logic        busy, done;

    int errors = 0;
    int checks = 0;
    vec_t vecs [4];

    des_round_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .decrypt  (decrypt),
        .data_in  (data_in),
        .key_in   (key_in),
        .f_r      (f_r),
        .f_key    (f_key),
        .f_out    (f_out),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;
    always_comb f_out = des_f(f_r, f_key);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called in the cycle after the start edge; waits for done and checks the completed block.
    task automatic finish_op(input vec_t v);
        int n;
        check({v.name, " busy after start"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({v.name, " latency"}, 64'(n), 64'd17);
        check({v.name, " data_out"}, data_out, v.exp);
        check({v.name, " busy at done"}, 64'(busy), 64'd0);
        check({v.name, " f_key idle"}, 64'(f_key), 64'd0);
`ifdef DES_KEY_ZEROIZE_EN
        check({v.name, " state zeroized"}, 64'({dut.c, dut.d, dut.l, dut.r} == 120'd0), 64'd1);
`else
        check({v.name, " state retained"}, 64'({dut.c, dut.d, dut.l, dut.r} != 120'd0), 64'd1);
`endif
    endtask

    task automatic run_op(input vec_t v);
        start   = 1'b1;
        decrypt = v.dec;
        key_in  = v.key;
        data_in = v.din;
        tick();
        start   = 1'b0;
        data_in = ~v.din;
        key_in  = ~v.key;
        decrypt = ~v.dec;
        finish_op(v);
        tick();
        check({v.name, " done pulse width"}, 64'(done), 64'd0);
        check({v.name, " data_out held"}, data_out, v.exp);
    endtask

    initial begin
        int n;
        int dcount;
        vecs[0] = '{"enc_kat1", 1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
        vecs[1] = '{"dec_kat1", 1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
        vecs[2] = '{"enc_kat2", 1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
        vecs[3] = '{"dec_kat2", 1'b1, 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};

        reset = 1'b1; start = 1'b0; decrypt = 1'b0; data_in = '0; key_in = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset data_out", data_out, 64'd0);
        check("reset f_key", 64'(f_key), 64'd0);
        check("reset f_r", 64'(f_r), 64'd0);

        for (int i = 0; i < 4; i++) run_op(vecs[i]);

        // Starts during ROUND and FINAL are ignored; a start in the done cycle is taken.
        start = 1'b1; decrypt = 1'b0; key_in = vecs[0].key; data_in = vecs[0].din;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == 5 || n == 10 || n == 16) begin
                start   = 1'b1;
                decrypt = 1'b1;
                data_in = 64'hDEADBEEFCAFEF00D ^ 64'(n);
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("ignored_start latency", 64'(n), 64'd17);
        check("ignored_start data_out", data_out, vecs[0].exp);
        start = 1'b1; decrypt = vecs[1].dec; key_in = vecs[1].key; data_in = vecs[1].din;
        tick();
        start = 1'b0;
        check("back_to_back done cleared", 64'(done), 64'd0);
        finish_op(vecs[1]);
        tick();

        // Reset mid-flight with start asserted aborts without done.
        start = 1'b1; decrypt = 1'b0; key_in = vecs[0].key; data_in = vecs[0].din;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort data_out", data_out, 64'd0);
        dcount = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done || busy) dcount++;
        end
        check("abort no activity", 64'(dcount), 64'd0);
        run_op(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
